uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive controller. It oversamples the asynchronous serial line, detects and qualifies the start bit, and sequences the 8-bit data shift register LSB-first. It checks the stop bit and presents each received byte on a valid/ready interface. It sits between the `rx` pin and the byte consumer (command decoder / FIFO), and generates all enable and select timing for the receive datapath.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is 4 to 65535.
- `DATA_BITS`, default 8: data bits per frame. Fixed at 8; any other value is a synthesis error.
- `clk` in, 1: system clock. Single clock domain.
- `rst_n` in, 1: asynchronous assert, active-low reset.
- `rx` in, 1: raw serial line, asynchronous, idles high.
- `rx_data` out, 8: received byte, stable while `rx_valid`=1.
- `rx_valid` out, 1: byte available.
- `rx_ready` in, 1: consumer accepts the byte. Transfer occurs when `rx_valid & rx_ready`.
- `busy` out, 1: a frame is in progress (state is not IDLE).
- `frame_err` out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_err` out, 1: one-cycle pulse when a new byte arrives while `rx_valid` is still set.

## Operation
- `rx` passes through a 2-flop synchronizer; the output is `rx_s`. `rx_s` resets to 1.
- FSM states:
  - **IDLE**: when `rx_s`=0, go to START and clear the counter.
  - **START**: count H = CLKS_PER_BIT/2 (floor) cycles, then sample `rx_s`. If 0, go to DATA with bit index 0. If 1 (glitch), go to IDLE with no error.
  - **DATA**: every CLKS_PER_BIT cycles, sample `rx_s` and shift it into bit 7 of the shift register (right shift, LSB first). After bit index 7, go to STOP.
  - **STOP**: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If 1: copy the shift register to `rx_data`, set `rx_valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `rx_data`/`rx_valid` unchanged, go to BREAK.
  - **BREAK**: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from restarting frames.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid & rx_ready`.
  - If a byte completes while `rx_valid`=1 and no accept occurs that cycle: the new byte overwrites `rx_data`, `rx_valid` stays 1, and `overrun_err` pulses.
  - If accept and completion happen in the same cycle: the new byte loads, `rx_valid` stays 1, and there is no overrun.
- The shift register holds its value except on sample cycles in DATA.
- Bit and cycle counters use $clog2 widths with no wrap. The cycle counter reloads to 0 at each sample.
- `rx_ready` is ignored while `rx_valid`=0.

## Timing
- Reset values: state IDLE; `rx_data`=0x00; `rx_valid`=0; `busy`=0; `frame_err`=0; `overrun_err`=0; counters 0; shift register 0; synchronizer flops 1.
- Define T0 as the first cycle with `rx_s`=0 in IDLE (2 to 3 cycles after the pin falls).
- Sample times:
  - Start check at T0+H.
  - Data bit i at T0+H+(i+1)·CLKS_PER_BIT.
  - Stop bit at T0+H+9·CLKS_PER_BIT.
- `rx_valid`, `frame_err` and `overrun_err` register and assert in the cycle after the stop sample.
- `busy` is 1 from T0+1 until the state returns to IDLE. BREAK counts as busy.
- Reset mid-frame: asynchronous return to reset values. The partial byte is lost and no error pulse is produced.
- A new start bit may be detected in the cycle after the return to IDLE, allowing back-to-back frames with one stop bit.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t`
  - `localparam UART_DATA_BITS = 8`
  - default `CLKS_PER_BIT`
- Sub-module `uart_rx_sync`: a 2-flop synchronizer with reset value 1, reusable for other asynchronous inputs.
- The FSM, counters, shift register and output register live in `uart_rx_ctrl`.

## Test plan
All scenarios use CLKS_PER_BIT=8 and 8N1 frames of 8 cycles per bit unless noted.
1. Frame 0xA5 with `rx_ready`=1: `rx_data`=0xA5, and `rx_valid` is high for exactly 1 cycle at T0+4+72+1. No errors.
2. A 3-cycle low glitch on an idle line: returns to IDLE at T0+4. `rx_valid`, `frame_err` and `busy` are 0 after return.
3. Frame 0x3C with the stop bit driven low and the line held low for 40 cycles: `frame_err` pulses once, `rx_valid` stays 0, `busy` stays 1 until the line returns high, and the following 0x55 frame is received correctly.
4. Frames 0x11 then 0x22 back-to-back with `rx_ready`=0: `overrun_err` pulses at the second completion, `rx_data`=0x22, `rx_valid`=1. Raising `rx_ready` for 1 cycle clears `rx_valid`.
5. `rst_n` low for 2 cycles during data bit 4: all outputs return to reset values immediately. A subsequent 0xF0 frame yields `rx_data`=0xF0.
6. Frames 0x00 and 0xFF back-to-back with a continuous `rx_ready` pulse at each completion: both are delivered, with no overrun and no frame error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 (idle line).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: start qualification at mid-bit, LSB-first shift,
// stop check and a single-entry valid/ready output register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  if (DATA_BITS != UART_DATA_BITS) begin : g_bad_data_bits
    $error("uart_rx_ctrl: DATA_BITS must be 8");
  end

  uart_rx_state_t state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bit_idx;
  logic [7:0]     shreg;
  logic           rx_s;
  logic           tick;

  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));

  // tick marks the one cycle in each bit period where rx_s is sampled
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (cnt == HALF_M1) begin
               tick      = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
             end
      DATA:  if (cnt == FULL_M1) begin
               tick = 1'b1;
               if (bit_idx == LAST_BIT) state_nxt = STOP;
             end
      STOP:  if (cnt == FULL_M1) begin
               tick      = 1'b1;
               state_nxt = rx_s ? IDLE : BREAK;
             end
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic shift_en, stop_ok, stop_bad;
  assign shift_en = tick && (state == DATA);
  assign stop_ok  = tick && (state == STOP) &&  rx_s;
  assign stop_bad = tick && (state == STOP) && !rx_s;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // Held at zero outside timed states so it never wraps during a long break
      if (tick || state == IDLE || state == BREAK) cnt <= '0;
      else                                         cnt <= cnt + CW'(1);

      if (tick && state == START)                  bit_idx <= '0;
      else if (shift_en && bit_idx != LAST_BIT)    bit_idx <= bit_idx + BW'(1);

      if (shift_en) shreg <= {rx_s, shreg[7:1]};

      frame_err   <= stop_bad;
      overrun_err <= stop_ok && rx_valid && !rx_ready;
      // A completing byte wins over an accept in the same cycle
      if (stop_ok) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench: pin waveform built up front, expected outputs derived from bit-sample times.
module tb_uart_rx_ctrl;
  localparam int C = 8;
  localparam int H = C / 2;
  localparam int N = 8000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err, overrun_err;

  uart_rx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  bit         pin[N], rdy[N], rstv[N];
  bit         e_valid[N], e_busy[N], e_ferr[N], e_ovr[N];
  logic [7:0] e_data[N];

  typedef struct {int cyc; int sig; int val; string nm;} pin_t;
  pin_t pins[$];

  int checks = 0, failures = 0;
  int wp = 0, cyc = 0;
  bit run = 1'b0, rdy_def = 1'b1;

  function automatic void put(bit v, int len);
    for (int i = 0; i < len; i++) if (wp < N) begin
      pin[wp] = v; rdy[wp] = rdy_def; wp++;
    end
  endfunction

  function automatic void frame(logic [7:0] b, bit stop);
    put(1'b0, C);
    for (int i = 0; i < 8; i++) put(b[i], C);
    put(stop, C);
  endfunction

  function automatic void pin_chk(int c, int s, int v, string nm);
    pins.push_back('{c, s, v, nm});
  endfunction

  // Synchronized line as seen by the receiver in cycle m
  function automatic bit rxs(int m);
    if (m < 2 || m >= N) return 1'b1;
    if (!(rstv[m] && rstv[m-1] && rstv[m-2])) return 1'b1;
    return pin[m-2];
  endfunction

  // Frame outcome from sample instants T0+H, T0+H+(i+1)C, T0+H+9C
  function automatic void build_model();
    int idle_from = 0, ft0 = 0, fend = 0, fsamp = 0, kind = 0;
    bit in_fr = 1'b0, v = 1'b0, fe = 1'b0, ov = 1'b0;
    logic [7:0] d = 8'h00, fb = 8'h00;
    for (int n = 0; n < N; n++) begin
      if (!rstv[n]) begin
        v = 0; fe = 0; ov = 0; d = 8'h00; in_fr = 0; idle_from = n + 1;
        e_valid[n] = 0; e_data[n] = 8'h00; e_ferr[n] = 0; e_ovr[n] = 0; e_busy[n] = 0;
        continue;
      end
      e_valid[n] = v; e_data[n] = d; e_ferr[n] = fe; e_ovr[n] = ov;
      if (in_fr && n >= fend) begin in_fr = 0; idle_from = fend; end
      e_busy[n] = in_fr && (n > ft0);
      if (!in_fr && n >= idle_from && !rxs(n)) begin
        in_fr = 1; ft0 = n; fsamp = n + H;
        if (rxs(fsamp)) begin
          kind = 0; fend = fsamp + 1;
        end else begin
          for (int i = 0; i < 8; i++) fb[i] = rxs(n + H + (i + 1) * C);
          fsamp = n + H + 9 * C;
          if (rxs(fsamp)) begin
            kind = 1; fend = fsamp + 1;
          end else begin
            kind = 2; fend = fsamp + 1;
            while (fend < N && !rxs(fend)) fend++;
            fend++;
          end
        end
      end
      fe = 0; ov = 0;
      if (in_fr && n == fsamp && kind == 1) begin
        ov = v && !rdy[n]; v = 1; d = fb;
      end else begin
        if (in_fr && n == fsamp && kind == 2) fe = 1;
        if (v && rdy[n]) v = 0;
      end
    end
  endfunction

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) if (run) begin
    int act;
    chk("rx_valid", int'(rx_valid), int'(e_valid[cyc]));
    chk("rx_data", int'(rx_data), int'(e_data[cyc]));
    chk("busy", int'(busy), int'(e_busy[cyc]));
    chk("frame_err", int'(frame_err), int'(e_ferr[cyc]));
    chk("overrun_err", int'(overrun_err), int'(e_ovr[cyc]));
    foreach (pins[k]) if (pins[k].cyc == cyc) begin
      case (pins[k].sig)
        0: act = int'(rx_valid);
        1: act = int'(rx_data);
        2: act = int'(busy);
        3: act = int'(frame_err);
        default: act = int'(overrun_err);
      endcase
      chk(pins[k].nm, act, pins[k].val);
    end
  end

  initial begin
    int f1, g, f3, f3b, f4, r4, f5, f5b, f6, rs;
    for (int i = 0; i < N; i++) begin pin[i] = 1; rstv[i] = 1; rdy[i] = 0; end
    for (int i = 0; i < 4; i++) rstv[i] = 0;
    pin_chk(0, 0, 0, "reset_valid"); pin_chk(0, 1, 0, "reset_data");
    pin_chk(0, 2, 0, "reset_busy");  pin_chk(0, 3, 0, "reset_ferr");
    pin_chk(0, 4, 0, "reset_ovr");

    // 1: clean frame, consumer always ready
    rdy_def = 1; put(1, 20);
    f1 = wp; frame(8'hA5, 1); put(1, 20);
    pin_chk(f1 + 79, 0, 1, "s1_valid");      pin_chk(f1 + 79, 1, 'hA5, "s1_data");
    pin_chk(f1 + 78, 0, 0, "s1_valid_pre");  pin_chk(f1 + 80, 0, 0, "s1_valid_post");
    pin_chk(f1 + 79, 3, 0, "s1_ferr");
    // 2: short glitch
    g = wp; put(0, 3); put(1, 20);
    pin_chk(g + 5, 2, 1, "s2_busy_in");  pin_chk(g + 8, 2, 0, "s2_busy_out");
    pin_chk(g + 8, 0, 0, "s2_valid");    pin_chk(g + 8, 3, 0, "s2_ferr");
    // 3: bad stop, line held low, then recovery
    f3 = wp; frame(8'h3C, 0); put(0, 40); put(1, 20);
    pin_chk(f3 + 79, 3, 1, "s3_ferr");        pin_chk(f3 + 80, 3, 0, "s3_ferr_end");
    pin_chk(f3 + 79, 0, 0, "s3_valid");       pin_chk(f3 + 122, 2, 1, "s3_busy_break");
    pin_chk(f3 + 123, 2, 0, "s3_busy_idle");
    f3b = wp; frame(8'h55, 1); put(1, 30);
    pin_chk(f3b + 79, 0, 1, "s3_valid55");    pin_chk(f3b + 79, 1, 'h55, "s3_data55");
    // 4: overrun with consumer stalled
    rdy_def = 0;
    f4 = wp; frame(8'h11, 1); frame(8'h22, 1); put(1, 10);
    r4 = wp; put(1, 1); rdy[r4] = 1; put(1, 20);
    pin_chk(f4 + 79, 1, 'h11, "s4_data11");   pin_chk(f4 + 79, 4, 0, "s4_no_ovr1");
    pin_chk(f4 + 158, 0, 1, "s4_held");       pin_chk(f4 + 159, 4, 1, "s4_ovr");
    pin_chk(f4 + 159, 1, 'h22, "s4_data22");  pin_chk(f4 + 160, 4, 0, "s4_ovr_end");
    pin_chk(r4, 0, 1, "s4_valid_at_acc");     pin_chk(r4 + 1, 0, 0, "s4_valid_clr");
    // 5: reset during data bit 4
    rdy_def = 1;
    f5 = wp; frame(8'hF3, 1); rstv[f5 + 44] = 0; rstv[f5 + 45] = 0; put(1, 20);
    pin_chk(f5 + 43, 2, 1, "s5_busy_pre");    pin_chk(f5 + 44, 2, 0, "s5_busy_rst");
    pin_chk(f5 + 44, 1, 0, "s5_data_rst");    pin_chk(f5 + 44, 0, 0, "s5_valid_rst");
    f5b = wp; frame(8'hF0, 1); put(1, 20);
    pin_chk(f5b + 79, 1, 'hF0, "s5_dataF0");  pin_chk(f5b + 79, 0, 1, "s5_validF0");
    // 6: back-to-back with accept pulses at each completion
    rdy_def = 0;
    f6 = wp; frame(8'h00, 1); frame(8'hFF, 1); put(1, 20);
    rdy[f6 + 79] = 1; rdy[f6 + 159] = 1;
    pin_chk(f6 + 79, 0, 1, "s6_valid00");     pin_chk(f6 + 80, 0, 0, "s6_clr00");
    pin_chk(f6 + 159, 1, 'hFF, "s6_dataFF");  pin_chk(f6 + 159, 4, 0, "s6_no_ovr");
    pin_chk(f6 + 160, 0, 0, "s6_clrFF");      pin_chk(f6 + 160, 3, 0, "s6_no_ferr");
    // random traffic: frames, bad stops, glitches, random ready
    rs = wp;
    while (wp < N - 300) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) put(0, $urandom_range(1, H));
      else begin
        frame(8'($urandom_range(0, 255)), r != 1);
        if (r == 1) put(0, $urandom_range(0, 20));
      end
      put(1, $urandom_range(0, 15));
    end
    for (int i = rs; i < N; i++) rdy[i] = 1'($urandom_range(0, 1));

    build_model();
    for (int n = 0; n < N; n++) begin
      @(posedge clk); #1;
      rx = pin[n]; rx_ready = rdy[n]; rst_n = rstv[n]; cyc = n; run = 1'b1;
    end
    @(posedge clk);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
